// File: rtl/or_event_counter.sv
// Synchronizes the async OR-gate output Z, detects its rising edges, and counts them with a threshold HIT pulse and a sticky OVF flag.
// Optional define OR_EVENT_CNT_SAT_EN selects a saturating counter; by default the counter wraps.
module or_event_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             Z,
    input  logic             EN,
    input  logic             CLR,
    input  logic [WIDTH-1:0] THRESH,
    output logic             EDGE,
    output logic [WIDTH-1:0] COUNT,
    output logic             HIT,
    output logic             OVF
);

    logic             r_z_s1;
    logic             r_z_s2;
    logic             r_z_d;
    logic             r_edge;
    logic [WIDTH-1:0] r_count;
    logic             r_hit;
    logic             r_ovf;

    logic             w_rise;
    logic             w_inc;
    logic             w_at_max;
    logic [WIDTH-1:0] w_next_count;
    logic             w_hit_ok;

    assign w_rise   = r_z_s2 & ~r_z_d;
    assign w_inc    = w_rise & EN & ~CLR;
    assign w_at_max = (r_count == '1);

`ifdef OR_EVENT_CNT_SAT_EN
    // Held at all-ones while saturated; HIT must not re-fire on a held value.
    assign w_next_count = w_at_max ? r_count : r_count + WIDTH'(1);
    assign w_hit_ok     = ~w_at_max;
`else
    assign w_next_count = r_count + WIDTH'(1);
    assign w_hit_ok     = 1'b1;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_z_s1  <= 1'b0;
            r_z_s2  <= 1'b0;
            r_z_d   <= 1'b0;
            r_edge  <= 1'b0;
            r_count <= '0;
            r_hit   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_z_s1 <= Z;
            r_z_s2 <= r_z_s1;
            r_z_d  <= r_z_s2;
            r_edge <= w_rise;
            if (CLR) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
                r_hit   <= 1'b0;
            end else if (w_inc) begin
                r_count <= w_next_count;
                if (w_at_max) begin
                    r_ovf <= 1'b1;
                end
                r_hit <= w_hit_ok & (w_next_count == THRESH);
            end else begin
                r_hit <= 1'b0;
            end
        end
    end

    assign EDGE  = r_edge;
    assign COUNT = r_count;
    assign HIT   = r_hit;
    assign OVF   = r_ovf;

endmodule

// File: tb/tb_or_event_counter.sv
// Directed self-checking bench for or_event_counter: an 8-bit instance for counting, gating, clear and reset, plus a 2-bit instance for wrap/saturate.
module tb_or_event_counter;

    logic       clk;
    logic       rst_n;
    logic       z;
    logic       en;
    logic       clr;
    logic [7:0] thresh8;
    logic [1:0] thresh2;
    logic       edge8, hit8, ovf8;
    logic [7:0] count8;
    logic       edge2, hit2, ovf2;
    logic [1:0] count2;

    int n_tests = 0;
    int n_fail  = 0;

    or_event_counter #(.WIDTH(8)) u_dut8 (
        .CLK(clk), .RST_N(rst_n), .Z(z), .EN(en), .CLR(clr), .THRESH(thresh8),
        .EDGE(edge8), .COUNT(count8), .HIT(hit8), .OVF(ovf8)
    );

    or_event_counter #(.WIDTH(2)) u_dut2 (
        .CLK(clk), .RST_N(rst_n), .Z(z), .EN(en), .CLR(clr), .THRESH(thresh2),
        .EDGE(edge2), .COUNT(count2), .HIT(hit2), .OVF(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // One Z pulse: 4 edges high, 4 edges low, driven and sampled on the falling edge.
    task automatic pulse(output int n_edge, output int edge_idx, output int cnt_at_edge,
                         output int n_hit8, output int n_hit2);
        n_edge = 0; edge_idx = -1; cnt_at_edge = -1; n_hit8 = 0; n_hit2 = 0;
        z = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (edge8) begin
                n_edge++;
                edge_idx    = i;
                cnt_at_edge = int'(count8);
            end
            if (hit8) n_hit8++;
            if (hit2) n_hit2++;
            if (i == 3) z = 1'b0;
        end
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    int ne, ei, ce, h8, h2, tot_edge;

    initial begin
        rst_n = 1'b0; z = 1'b0; en = 1'b1; clr = 1'b0;
        thresh8 = 8'd3; thresh2 = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_edge",  int'(edge8),  0);
        chk("rst_count", int'(count8), 0);
        chk("rst_hit",   int'(hit8),   0);
        chk("rst_ovf",   int'(ovf8),   0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset then count to threshold 3
        for (int k = 1; k <= 3; k++) begin
            pulse(ne, ei, ce, h8, h2);
            chk($sformatf("cnt_edges_p%0d", k), ne, 1);
            chk($sformatf("cnt_lat_p%0d", k), ei, 2);
            chk($sformatf("cnt_at_edge_p%0d", k), ce, k);
            chk($sformatf("cnt_hit_p%0d", k), h8, (k == 3) ? 1 : 0);
            chk($sformatf("cnt_count_p%0d", k), int'(count8), k);
        end
        chk("cnt_ovf", int'(ovf8), 0);

        // Enable gating
        do_clr();
        chk("clr_count", int'(count8), 0);
        en = 1'b0;
        tot_edge = 0;
        for (int k = 0; k < 2; k++) begin
            pulse(ne, ei, ce, h8, h2);
            tot_edge += ne;
        end
        chk("en0_count", int'(count8), 0);
        en = 1'b1;
        pulse(ne, ei, ce, h8, h2);
        tot_edge += ne;
        chk("en_edges", tot_edge, 3);
        chk("en_count", int'(count8), 1);

        // Clear colliding with a rise, COUNT=5 beforehand
        do_clr();
        thresh8 = 8'd6;
        for (int k = 0; k < 5; k++) pulse(ne, ei, ce, h8, h2);
        chk("coll_pre_count", int'(count8), 5);
        z = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("coll_edge",  int'(edge8),  1);
        chk("coll_count", int'(count8), 0);
        chk("coll_ovf",   int'(ovf8),   0);
        chk("coll_hit",   int'(hit8),   0);
        @(negedge clk);
        z = 1'b0;
        chk("coll_hit_after", int'(hit8), 0);
        repeat (5) @(negedge clk);
        chk("coll_count_after", int'(count8), 0);

        // 2-bit instance: wrap (default) or saturate
        do_clr();
`ifdef OR_EVENT_CNT_SAT_EN
        thresh2 = 2'd3;
        for (int k = 1; k <= 5; k++) begin
            pulse(ne, ei, ce, h8, h2);
            chk($sformatf("sat_count_p%0d", k), int'(count2), (k >= 3) ? 3 : k);
            chk($sformatf("sat_ovf_p%0d", k), int'(ovf2), (k >= 4) ? 1 : 0);
            chk($sformatf("sat_hit_p%0d", k), h2, (k == 3) ? 1 : 0);
        end
`else
        thresh2 = 2'd0;
        for (int k = 1; k <= 6; k++) begin
            pulse(ne, ei, ce, h8, h2);
            chk($sformatf("wrap_count_p%0d", k), int'(count2), k % 4);
            chk($sformatf("wrap_ovf_p%0d", k), int'(ovf2), (k >= 4) ? 1 : 0);
            chk($sformatf("wrap_hit_p%0d", k), h2, (k == 4) ? 1 : 0);
        end
`endif
        do_clr();
        chk("w2_clr_ovf",   int'(ovf2),   0);
        chk("w2_clr_count", int'(count2), 0);

        // Asynchronous reset mid-count with Z high
        thresh8 = 8'd0;
        for (int k = 0; k < 2; k++) pulse(ne, ei, ce, h8, h2);
        chk("ar_pre_count", int'(count8), 2);
        z = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_edge",   int'(edge8),  0);
        chk("ar_count",  int'(count8), 0);
        chk("ar_hit",    int'(hit8),   0);
        chk("ar_ovf",    int'(ovf8),   0);
        chk("ar_count2", int'(count2), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tot_edge = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (edge8) tot_edge++;
        end
        chk("ar_rel_edges", tot_edge, 1);
        chk("ar_rel_count", int'(count8), 1);
        z = 1'b0;
        repeat (4) @(negedge clk);
        chk("ar_final_count", int'(count8), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
